// File: rtl/fbuf_pingpong_ctrl.sv
// Ping-pong controller for the packed 1-bpp frame buffer: routes packer writes into one bank and reads the other bank out to UART TX.
// Optional build macro FBUF_AUTO_TX_EN: stream every completed frame automatically and ignore tx_start.
module fbuf_pingpong_ctrl #(
  parameter int DEPTH  = 5160,
  parameter int ADDR_W = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pk_we,
  input  logic [7:0]        pk_wData,
  input  logic [ADDR_W-1:0] pk_wAddr,
  input  logic              pk_frame_tick,
  output logic              mem_we,
  output logic [ADDR_W:0]   mem_wAddr,
  output logic [7:0]        mem_wData,
  output logic [ADDR_W:0]   mem_rAddr,
  input  logic [7:0]        mem_rData,
  input  logic              tx_start,
  output logic              tx_valid,
  output logic [7:0]        tx_data,
  input  logic              tx_ready,
  output logic              frame_ready,
  output logic              busy,
  output logic [7:0]        drop_cnt
);

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_RD_ADDR = 3'd1,
    S_RD_WAIT = 3'd2,
    S_RD_HOLD = 3'd3,
    S_DONE    = 3'd4
  } state_t;

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_wr_bank;
  logic              w_wr_bank_nxt;
  logic              r_full;
  logic              w_full_nxt;
  logic              w_full_eff;
  logic [ADDR_W-1:0] r_rd_addr;
  logic [ADDR_W-1:0] w_rd_addr_nxt;
  logic              r_tx_valid;
  logic              w_tx_valid_nxt;
  logic [7:0]        r_tx_data;
  logic [7:0]        w_tx_data_nxt;
  logic [7:0]        r_drop_cnt;
  logic [7:0]        w_drop_cnt_nxt;
  logic              w_start;

`ifdef FBUF_AUTO_TX_EN
  logic w_unused_tx_start;
  assign w_unused_tx_start = tx_start;
  assign w_start           = 1'b1;
`else
  assign w_start = tx_start;
`endif

  // Read sequencer: one byte per RD_ADDR/RD_WAIT/RD_HOLD pass; DONE releases the read bank.
  always_comb begin
    w_state_nxt    = r_state;
    w_rd_addr_nxt  = r_rd_addr;
    w_tx_valid_nxt = r_tx_valid;
    w_tx_data_nxt  = r_tx_data;
    w_full_eff     = r_full;
    case (r_state)
      S_IDLE: begin
        if (r_full && w_start) begin
          w_state_nxt   = S_RD_ADDR;
          w_rd_addr_nxt = {ADDR_W{1'b0}};
        end else begin
          w_state_nxt = S_IDLE;
        end
      end
      S_RD_ADDR: begin
        w_state_nxt = S_RD_WAIT;
      end
      S_RD_WAIT: begin
        w_tx_data_nxt  = mem_rData;
        w_tx_valid_nxt = 1'b1;
        w_state_nxt    = S_RD_HOLD;
      end
      S_RD_HOLD: begin
        if (tx_ready) begin
          w_tx_valid_nxt = 1'b0;
          if (r_rd_addr == LAST_ADDR) begin
            w_state_nxt = S_DONE;
          end else begin
            w_rd_addr_nxt = r_rd_addr + ADDR_W'(1);
            w_state_nxt   = S_RD_ADDR;
          end
        end else begin
          w_state_nxt = S_RD_HOLD;
        end
      end
      S_DONE: begin
        // The clear wins over a same-cycle frame_tick, so that tick swaps instead of dropping.
        w_full_eff  = 1'b0;
        w_state_nxt = S_IDLE;
      end
      default: begin
        w_state_nxt    = S_IDLE;
        w_tx_valid_nxt = 1'b0;
      end
    endcase
  end

  // Bank swap on frame_tick, or count a dropped frame when the read bank is still occupied.
  always_comb begin
    w_wr_bank_nxt  = r_wr_bank;
    w_full_nxt     = w_full_eff;
    w_drop_cnt_nxt = r_drop_cnt;
    if (pk_frame_tick) begin
      if (w_full_eff) begin
        if (r_drop_cnt != 8'hFF) begin
          w_drop_cnt_nxt = r_drop_cnt + 8'd1;
        end else begin
          w_drop_cnt_nxt = r_drop_cnt;
        end
      end else begin
        w_wr_bank_nxt = ~r_wr_bank;
        w_full_nxt    = 1'b1;
      end
    end else begin
      w_full_nxt = w_full_eff;
    end
  end

  // State register; reset abandons any readout in flight.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state    <= S_IDLE;
      r_wr_bank  <= 1'b0;
      r_full     <= 1'b0;
      r_rd_addr  <= {ADDR_W{1'b0}};
      r_tx_valid <= 1'b0;
      r_tx_data  <= 8'h00;
      r_drop_cnt <= 8'h00;
    end else begin
      r_state    <= w_state_nxt;
      r_wr_bank  <= w_wr_bank_nxt;
      r_full     <= w_full_nxt;
      r_rd_addr  <= w_rd_addr_nxt;
      r_tx_valid <= w_tx_valid_nxt;
      r_tx_data  <= w_tx_data_nxt;
      r_drop_cnt <= w_drop_cnt_nxt;
    end
  end

  assign mem_we      = pk_we;
  assign mem_wAddr   = {r_wr_bank, pk_wAddr};
  assign mem_wData   = pk_wData;
  assign mem_rAddr   = {~r_wr_bank, r_rd_addr};
  assign tx_valid    = r_tx_valid;
  assign tx_data     = r_tx_data;
  assign drop_cnt    = r_drop_cnt;
  assign busy        = (r_state != S_IDLE);
  assign frame_ready = r_full && (r_state == S_IDLE);

endmodule

// File: tb/tb_fbuf_pingpong_ctrl.sv
// Bench for fbuf_pingpong_ctrl: randomized writes and tx_ready against a frame-level reference model.
module tb_fbuf_pingpong_ctrl;
  localparam int DEPTH = 5160;
  localparam int AW    = 13;

  logic          clk = 1'b0;
  logic          reset;
  logic          pk_we;
  logic [7:0]    pk_wData;
  logic [AW-1:0] pk_wAddr;
  logic          pk_frame_tick;
  logic          mem_we;
  logic [AW:0]   mem_wAddr;
  logic [7:0]    mem_wData;
  logic [AW:0]   mem_rAddr;
  logic [7:0]    mem_rData;
  logic          tx_start;
  logic          tx_valid;
  logic [7:0]    tx_data;
  logic          tx_ready;
  logic          frame_ready;
  logic          busy;
  logic [7:0]    drop_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model: frame contents per bank plus bank/full/drop bookkeeping
  int         m_wr_bank;
  int         m_full;
  int         m_drop;
  int         m_clear_now;
  logic [7:0] m_mem [0:1][0:DEPTH-1];

  logic [7:0] bram [0:16383];

  fbuf_pingpong_ctrl dut (
    .clk(clk), .reset(reset),
    .pk_we(pk_we), .pk_wData(pk_wData), .pk_wAddr(pk_wAddr), .pk_frame_tick(pk_frame_tick),
    .mem_we(mem_we), .mem_wAddr(mem_wAddr), .mem_wData(mem_wData),
    .mem_rAddr(mem_rAddr), .mem_rData(mem_rData),
    .tx_start(tx_start), .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .frame_ready(frame_ready), .busy(busy), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (mem_we) bram[mem_wAddr] <= mem_wData;
    mem_rData <= bram[mem_rAddr];
  end

  task automatic model_reset();
    m_wr_bank   = 0;
    m_full      = 0;
    m_drop      = 0;
    m_clear_now = 0;
  endtask

  // Apply this cycle's inputs to the model, then advance to 1 time unit after the edge
  task automatic cyc();
    if (!reset) begin
      if (pk_we) m_mem[m_wr_bank][pk_wAddr] = pk_wData;
      if (pk_frame_tick) begin
        if (m_full != 0 && m_clear_now == 0) m_drop = (m_drop == 255) ? 255 : m_drop + 1;
        else begin
          m_wr_bank = 1 - m_wr_bank;
          m_full    = 1;
        end
      end else if (m_clear_now != 0) begin
        m_full = 0;
      end
    end
    m_clear_now = 0;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    #1;
    reset = 1'b1;
    model_reset();
    cyc();
    cyc();
    n_checks++; if (tx_valid !== 1'b0) begin n_fail++; $display("FAIL rst_tx_valid got %b want 0", tx_valid); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("FAIL rst_tx_data got %h want 00", tx_data); end
    n_checks++; if (drop_cnt !== 8'h00) begin n_fail++; $display("FAIL rst_drop got %h want 00", drop_cnt); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rst_busy got %b want 0", busy); end
    n_checks++; if (frame_ready !== 1'b0) begin n_fail++; $display("FAIL rst_frame_ready got %b want 0", frame_ready); end
    n_checks++; if (mem_rAddr !== 14'h2000) begin n_fail++; $display("FAIL rst_rAddr got %h want 2000", mem_rAddr); end
    reset = 1'b0;
    cyc();
    n_checks++; if (busy !== 1'b0 || frame_ready !== 1'b0) begin n_fail++; $display("FAIL post_rst_idle got busy=%b fr=%b want 0 0", busy, frame_ready); end
  endtask

  task automatic write_frame(input bit rnd);
    for (int a = 0; a < DEPTH; a++) begin
      pk_we    = 1'b1;
      pk_wAddr = AW'(a);
      pk_wData = rnd ? 8'($urandom_range(255)) : 8'(a);
      #1;
      n_checks++;
      if (mem_we !== 1'b1 || mem_wAddr !== {m_wr_bank[0], pk_wAddr} || mem_wData !== pk_wData) begin
        n_fail++; $display("FAIL write_path got we=%b addr=%h data=%h want 1 %h %h", mem_we, mem_wAddr, mem_wData, {m_wr_bank[0], pk_wAddr}, pk_wData);
      end
      cyc();
    end
    pk_we = 1'b0;
  endtask

  task automatic frame_tick();
    pk_frame_tick = 1'b1;
    cyc();
    pk_frame_tick = 1'b0;
  endtask

  task automatic do_readout(input int stall_pct, input int abort_at, input bit tick_done);
    int cnt = 0;
    int iters = 0;
    int rb = 1 - m_wr_bank;
    int limit = (abort_at > 0) ? abort_at : DEPTH;
    bit hold_v = 1'b0;
    bit hs;
    logic [7:0] held = 8'h00;
    tx_start = 1'b1;
    while (cnt < limit && iters < DEPTH * 6) begin
      tx_ready = ($urandom_range(99) >= stall_pct);
      if (tx_valid) begin
        n_checks++;
        if (mem_rAddr !== {rb[0], cnt[AW-1:0]}) begin n_fail++; $display("FAIL rd_addr got %h want %h", mem_rAddr, {rb[0], cnt[AW-1:0]}); end
        n_checks++;
        if (hold_v) begin
          if (tx_data !== held) begin n_fail++; $display("FAIL tx_stable got %h want %h", tx_data, held); end
        end else begin
          if (tx_data !== m_mem[rb][cnt]) begin n_fail++; $display("FAIL tx_byte[%0d] got %h want %h", cnt, tx_data, m_mem[rb][cnt]); end
        end
        held   = tx_data;
        hold_v = 1'b1;
      end
      hs = tx_valid && tx_ready;
      cyc();
      iters++;
      tx_start = 1'b0;
      if (hs) begin
        cnt++;
        hold_v = 1'b0;
      end
    end
    tx_ready = 1'b0;
    n_checks++; if (cnt != limit) begin n_fail++; $display("FAIL handshake_count got %0d want %0d", cnt, limit); end
    if (abort_at == 0) begin
      if (stall_pct == 0) begin
        n_checks++; if (iters != 3 * DEPTH + 1) begin n_fail++; $display("FAIL throughput got %0d cycles want %0d", iters, 3 * DEPTH + 1); end
      end
      m_clear_now   = 1;
      pk_frame_tick = tick_done;
      cyc();
      pk_frame_tick = 1'b0;
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL end_busy got %b want 0", busy); end
      n_checks++; if (frame_ready !== m_full[0]) begin n_fail++; $display("FAIL end_frame_ready got %b want %b", frame_ready, m_full[0]); end
      n_checks++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL end_drop got %0d want %0d", drop_cnt, m_drop); end
      n_checks++; if (mem_wAddr[AW] !== m_wr_bank[0]) begin n_fail++; $display("FAIL end_wr_bank got %b want %b", mem_wAddr[AW], m_wr_bank[0]); end
    end
  endtask

  task automatic test_write_swap();
    write_frame(1'b0);
    frame_tick();
    n_checks++; if (mem_wAddr[AW] !== 1'b1) begin n_fail++; $display("FAIL swap_wr_bank got %b want 1", mem_wAddr[AW]); end
    n_checks++; if (mem_rAddr[AW] !== 1'b0) begin n_fail++; $display("FAIL swap_rd_bank got %b want 0", mem_rAddr[AW]); end
    n_checks++; if (frame_ready !== 1'b1) begin n_fail++; $display("FAIL swap_frame_ready got %b want 1", frame_ready); end
  endtask

  task automatic test_start_ignored();
    tx_start = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL start_ignored busy got %b want 0", busy); end
    end
    tx_start = 1'b0;
  endtask

  task automatic test_drop();
    write_frame(1'b1);
    frame_tick();
    n_checks++; if (frame_ready !== 1'b1 || drop_cnt !== 8'h00) begin n_fail++; $display("FAIL drop_first got fr=%b drop=%0d want 1 0", frame_ready, drop_cnt); end
    frame_tick();
    n_checks++; if (drop_cnt !== 8'(m_drop)) begin n_fail++; $display("FAIL drop_second got %0d want %0d", drop_cnt, m_drop); end
    n_checks++; if (mem_wAddr[AW] !== m_wr_bank[0]) begin n_fail++; $display("FAIL drop_bank got %b want %b", mem_wAddr[AW], m_wr_bank[0]); end
    for (int i = 0; i < 300; i++) frame_tick();
    n_checks++; if (drop_cnt !== 8'(m_drop) || m_drop != 255) begin n_fail++; $display("FAIL drop_saturate got %0d want 255", drop_cnt); end
  endtask

  task automatic test_done_tick();
    reset = 1'b1;
    model_reset();
    cyc();
    reset = 1'b0;
    cyc();
    frame_tick();
    do_readout(0, 0, 1'b1);
    n_checks++; if (frame_ready !== 1'b1 || drop_cnt !== 8'h00 || mem_wAddr[AW] !== 1'b0) begin
      n_fail++; $display("FAIL done_tick got fr=%b drop=%0d bank=%b want 1 0 0", frame_ready, drop_cnt, mem_wAddr[AW]);
    end
  endtask

  task automatic test_abort();
    do_readout(0, 100, 1'b0);
    reset = 1'b1;
    model_reset();
    #1;
    for (int k = 0; k < 2; k++) begin
      n_checks++;
      if (tx_valid !== 1'b0 || tx_data !== 8'h00 || busy !== 1'b0 || frame_ready !== 1'b0 || drop_cnt !== 8'h00 || mem_rAddr !== 14'h2000) begin
        n_fail++; $display("FAIL abort_reset got v=%b d=%h b=%b fr=%b drop=%h ra=%h want 0 00 0 0 00 2000", tx_valid, tx_data, busy, frame_ready, drop_cnt, mem_rAddr);
      end
      cyc();
    end
    reset = 1'b0;
    cyc();
  endtask

  task automatic test_auto();
    frame_tick();
    cyc();
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL auto_start busy got %b want 1", busy); end
  endtask

  initial begin
    reset         = 1'b0;
    pk_we         = 1'b0;
    pk_wData      = 8'h00;
    pk_wAddr      = '0;
    pk_frame_tick = 1'b0;
    tx_start      = 1'b0;
    tx_ready      = 1'b0;
    model_reset();
    test_reset();
`ifdef FBUF_AUTO_TX_EN
    test_auto();
`else
    test_write_swap();
    do_readout(0, 0, 1'b0);
    test_start_ignored();
    test_drop();
    do_readout(30, 0, 1'b0);
    test_done_tick();
    test_abort();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
